// File: rtl/mips_pkg.sv
// Shared MIPS opcode constants and small opcode-class helpers used by the ID stage.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;

    localparam logic [4:0] REG_RA   = 5'd31;

    // Instructions whose rt field is a source operand rather than a destination.
    function automatic logic reads_rt(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_BEQ) || (op == OP_BNE) || (op == OP_SW);
    endfunction

    function automatic logic zero_ext(input logic [5:0] op);
        return (op == OP_ANDI) || (op == OP_ORI) || (op == OP_XORI);
    endfunction

    function automatic logic writes_reg(input logic [5:0] op);
        return !((op == OP_BEQ) || (op == OP_BNE) || (op == OP_J) || (op == OP_SW));
    endfunction

endpackage

// File: rtl/regfile_2r1w.sv
// Register file: two combinational reads, one synchronous write, r0 hard-wired to zero.
// PIPE_ID_WB_BYPASS_EN forwards same-cycle write data onto matching reads.
module regfile_2r1w #(
    parameter int DATA_W = 32,
    parameter int NREGS  = 32,
    localparam int ADDR_W = $clog2(NREGS)
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              we,
    input  logic [ADDR_W-1:0] wadr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] radr1,
    input  logic [ADDR_W-1:0] radr2,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2
);

    logic [DATA_W-1:0] rf_q [NREGS];

    genvar gi;
    generate
        for (gi = 0; gi < NREGS; gi++) begin : g_reg
            if (gi == 0) begin : g_zero
                assign rf_q[gi] = '0;
            end else begin : g_flop
                logic [DATA_W-1:0] q_reg;
                always_ff @(posedge CLK or posedge RST) begin
                    if (RST) begin
                        q_reg <= '0;
                    end else if (we && (wadr == ADDR_W'(gi))) begin
                        q_reg <= wdata;
                    end
                end
                assign rf_q[gi] = q_reg;
            end
        end
    endgenerate

    always_comb begin
        rdata1 = rf_q[radr1];
        rdata2 = rf_q[radr2];
`ifdef PIPE_ID_WB_BYPASS_EN
        // r0 is never forwarded: it has no storage and must always read zero.
        if (we && (wadr == radr1) && (radr1 != '0)) rdata1 = wdata;
        if (we && (wadr == radr2) && (radr2 != '0)) rdata2 = wdata;
`endif
    end

endmodule

// File: rtl/pipe_id.sv
// MIPS instruction-decode stage: decode, load-use hazard detection, ID/EX register, bubble counter.
// Define PIPE_ID_WB_BYPASS_EN to forward same-cycle write-back data into register reads.
module pipe_id
    import mips_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int NREGS  = 32,
    localparam int ADDR_W = $clog2(NREGS)
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       Ins,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_adr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_rdata1,
    output logic [DATA_W-1:0] out_rdata2,
    output logic [DATA_W-1:0] out_ed,
    output logic [5:0]        out_op,
    output logic [ADDR_W-1:0] out_wadr,
    output logic              out_we,
    output logic [15:0]       stall_cnt
);

    logic [5:0]        op;
    logic [ADDR_W-1:0] rs_adr, rt_adr, rd_adr;
    logic [15:0]       imm;
    logic [DATA_W-1:0] rs_data, rt_data;
    logic [DATA_W-1:0] imm_sx, imm_zx, ed_next;
    logic [ADDR_W-1:0] wadr_next;
    logic              hazard, accept;

    assign op     = Ins[31:26];
    assign rs_adr = Ins[21 +: ADDR_W];
    assign rt_adr = Ins[16 +: ADDR_W];
    assign rd_adr = Ins[11 +: ADDR_W];
    assign imm    = Ins[15:0];

    regfile_2r1w #(
        .DATA_W (DATA_W),
        .NREGS  (NREGS)
    ) u_rf (
        .CLK    (CLK),
        .RST    (RST),
        .we     (wb_en),
        .wadr   (wb_adr),
        .wdata  (wb_data),
        .radr1  (rs_adr),
        .radr2  (rt_adr),
        .rdata1 (rs_data),
        .rdata2 (rt_data)
    );

    assign imm_sx = DATA_W'($signed(imm));
    assign imm_zx = DATA_W'(imm);

    always_comb begin
        ed_next = imm_sx;
        if (zero_ext(op)) ed_next = imm_zx;

        wadr_next = rt_adr;
        if (op == OP_JAL) begin
            wadr_next = REG_RA[ADDR_W-1:0];
        end else if (op == OP_RTYPE) begin
            wadr_next = rd_adr;
        end
    end

    // A load in ID/EX whose target feeds this instruction cannot be satisfied yet.
    assign hazard = in_valid && out_valid && (out_op == OP_LW) && (out_wadr != '0) &&
                    ((out_wadr == rs_adr) || ((out_wadr == rt_adr) && reads_rt(op)));

    assign in_ready = !RST && (!out_valid || out_ready) && !hazard;
    assign accept   = in_valid && in_ready;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            out_valid  <= 1'b0;
            out_rdata1 <= '0;
            out_rdata2 <= '0;
            out_ed     <= '0;
            out_op     <= '0;
            out_wadr   <= '0;
            out_we     <= 1'b0;
        end else if (accept) begin
            out_valid  <= 1'b1;
            out_rdata1 <= rs_data;
            out_rdata2 <= rt_data;
            out_ed     <= ed_next;
            out_op     <= op;
            out_wadr   <= wadr_next;
            out_we     <= writes_reg(op);
        end else if (out_ready) begin
            out_valid  <= 1'b0;
        end
    end

    // A hazard only turns into a bubble when EX drains the load this cycle.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            stall_cnt <= '0;
        end else if (hazard && out_ready && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_pipe_id.sv
// Scoreboard bench for pipe_id: directed instructions push expected ID/EX contents,
// a negedge monitor pops and compares whenever EX consumes an output.
module tb_pipe_id;

    localparam int DATA_W = 32;
    localparam int NREGS  = 32;
    localparam int ADDR_W = 5;

    typedef struct packed {
        logic [31:0] r1;
        logic [31:0] r2;
        logic [31:0] ed;
        logic [5:0]  op;
        logic [4:0]  wadr;
        logic        we;
    } exp_t;

    logic              CLK = 1'b0;
    logic              RST;
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       Ins;
    logic              wb_en;
    logic [ADDR_W-1:0] wb_adr;
    logic [DATA_W-1:0] wb_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_rdata1;
    logic [DATA_W-1:0] out_rdata2;
    logic [DATA_W-1:0] out_ed;
    logic [5:0]        out_op;
    logic [ADDR_W-1:0] out_wadr;
    logic              out_we;
    logic [15:0]       stall_cnt;

    int   checks = 0;
    int   errors = 0;
    int   tx_n   = 0;
    exp_t exp_q[$];
    exp_t mon_e;

    pipe_id #(
        .DATA_W (DATA_W),
        .NREGS  (NREGS)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .Ins        (Ins),
        .wb_en      (wb_en),
        .wb_adr     (wb_adr),
        .wb_data    (wb_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_rdata1 (out_rdata1),
        .out_rdata2 (out_rdata2),
        .out_ed     (out_ed),
        .out_op     (out_op),
        .out_wadr   (out_wadr),
        .out_we     (out_we),
        .stall_cnt  (stall_cnt)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%08h required 0x%08h", name, act, req);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] ed,
                                input logic [5:0] op, input logic [4:0] wadr, input logic we);
        exp_t e;
        e.r1 = r1; e.r2 = r2; e.ed = ed; e.op = op; e.wadr = wadr; e.we = we;
        return e;
    endfunction

    // Monitor: an output transfers at the next rising edge when valid and ready are both high.
    always @(negedge CLK) begin
        if (!RST && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got op 0x%02h required no output", out_op);
            end else begin
                mon_e = exp_q.pop_front();
                chk($sformatf("tx%0d.rdata1", tx_n), out_rdata1, mon_e.r1);
                chk($sformatf("tx%0d.rdata2", tx_n), out_rdata2, mon_e.r2);
                chk($sformatf("tx%0d.ed", tx_n), out_ed, mon_e.ed);
                chk($sformatf("tx%0d.op", tx_n), 32'(out_op), 32'(mon_e.op));
                chk($sformatf("tx%0d.wadr", tx_n), 32'(out_wadr), 32'(mon_e.wadr));
                chk($sformatf("tx%0d.we", tx_n), 32'(out_we), 32'(mon_e.we));
                $display("tx %0d: op=0x%02h rdata1=0x%08h rdata2=0x%08h ed=0x%08h wadr=%0d we=%0d stall_cnt=%0d",
                         tx_n, out_op, out_rdata1, out_rdata2, out_ed, out_wadr, out_we, stall_cnt);
                tx_n++;
            end
        end
    end

    task automatic issue(input logic [31:0] ins, input exp_t e);
        int n;
        exp_q.push_back(e);
        Ins      = ins;
        in_valid = 1'b1;
        n = 0;
        @(negedge CLK);
        while (!in_ready && n < 50) begin
            n++;
            @(negedge CLK);
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got in_ready=0 required 1 within 50 cycles (ins 0x%08h)", ins);
        end
        @(posedge CLK); #1;
        in_valid = 1'b0;
    endtask

    task automatic wb_write(input logic [ADDR_W-1:0] adr, input logic [DATA_W-1:0] data);
        wb_en   = 1'b1;
        wb_adr  = adr;
        wb_data = data;
        @(posedge CLK); #1;
        wb_en   = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish required finish before 200000 time units");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] byp_exp;
        int n;
`ifdef PIPE_ID_WB_BYPASS_EN
        byp_exp = 32'hA5A5A5A5;
`else
        byp_exp = 32'h0;
`endif
        // Reset with an instruction on the input: it must be dropped.
        RST = 1'b1; in_valid = 1'b1; Ins = 32'h00A01820; out_ready = 1'b1;
        wb_en = 1'b0; wb_adr = '0; wb_data = '0;
        repeat (2) @(negedge CLK);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
        chk("rst_rdata1", out_rdata1, 32'd0);
        @(posedge CLK); #1;
        in_valid = 1'b0; RST = 1'b0;
        @(posedge CLK); #1;

        // First instruction after reset reads zero; then r5 written and read back.
        issue(32'h00A01820, mk(32'h0, 32'h0, 32'h00001820, 6'h00, 5'd3, 1'b1));
        wb_write(5'd5, 32'h12345678);
        issue(32'h00A01820, mk(32'h12345678, 32'h0, 32'h00001820, 6'h00, 5'd3, 1'b1));
        issue(32'h34028000, mk(32'h0, 32'h0, 32'h00008000, 6'h0D, 5'd2, 1'b1));
        issue(32'h20028000, mk(32'h0, 32'h0, 32'hFFFF8000, 6'h08, 5'd2, 1'b1));
        issue(32'h0C000010, mk(32'h0, 32'h0, 32'h00000010, 6'h03, 5'd31, 1'b1));
        issue(32'h10A5FFFF, mk(32'h12345678, 32'h12345678, 32'hFFFFFFFF, 6'h04, 5'd5, 1'b0));
        issue(32'hAC050004, mk(32'h0, 32'h12345678, 32'h00000004, 6'h2B, 5'd5, 1'b0));

        // Load-use hazards.
        wb_write(5'd4, 32'h00000044);
        issue(32'h8C240000, mk(32'h0, 32'h44, 32'h0, 6'h23, 5'd4, 1'b1));
        issue(32'h00813020, mk(32'h44, 32'h0, 32'h00003020, 6'h00, 5'd6, 1'b1));
        chk("stall_after_add", 32'(stall_cnt), 32'd1);
        issue(32'h8C240000, mk(32'h0, 32'h44, 32'h0, 6'h23, 5'd4, 1'b1));
        issue(32'hAC040000, mk(32'h0, 32'h44, 32'h0, 6'h2B, 5'd4, 1'b0));
        chk("stall_after_sw", 32'(stall_cnt), 32'd2);
        issue(32'h8C200000, mk(32'h0, 32'h0, 32'h0, 6'h23, 5'd0, 1'b1));
        issue(32'h00003020, mk(32'h0, 32'h0, 32'h00003020, 6'h00, 5'd6, 1'b1));
        chk("stall_after_r0", 32'(stall_cnt), 32'd2);
        issue(32'h8C240000, mk(32'h0, 32'h44, 32'h0, 6'h23, 5'd4, 1'b1));
        issue(32'h20040005, mk(32'h0, 32'h44, 32'h00000005, 6'h08, 5'd4, 1'b1));
        chk("stall_after_addi", 32'(stall_cnt), 32'd2);

        // Back-pressure: EX holds off for three cycles with a second instruction waiting.
        @(posedge CLK); #1;
        out_ready = 1'b0;
        issue(32'h34A900FF, mk(32'h12345678, 32'h0, 32'h000000FF, 6'h0D, 5'd9, 1'b1));
        Ins = 32'h380AFFFF; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            chk($sformatf("hold%0d.in_ready", i), 32'(in_ready), 32'd0);
            chk($sformatf("hold%0d.out_valid", i), 32'(out_valid), 32'd1);
            chk($sformatf("hold%0d.rdata1", i), out_rdata1, 32'h12345678);
            chk($sformatf("hold%0d.ed", i), out_ed, 32'h000000FF);
        end
        @(posedge CLK); #1;
        out_ready = 1'b1;
        issue(32'h380AFFFF, mk(32'h0, 32'h0, 32'h0000FFFF, 6'h0E, 5'd10, 1'b1));

        // Write-back to r7 in the same cycle r7 is read.
        wb_en = 1'b1; wb_adr = 5'd7; wb_data = 32'hA5A5A5A5;
        issue(32'h00E04020, mk(byp_exp, 32'h0, 32'h00004020, 6'h00, 5'd8, 1'b1));
        wb_en = 1'b0;
        issue(32'h00E04020, mk(32'hA5A5A5A5, 32'h0, 32'h00004020, 6'h00, 5'd8, 1'b1));

        // Drain before the mid-stream reset so no expectation is left stale.
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            n++;
            @(negedge CLK);
        end
        chk("drain_before_reset", 32'(exp_q.size()), 32'd0);
        @(posedge CLK); #1;
        out_ready = 1'b0;
        Ins = 32'h00A01820; in_valid = 1'b1;
        @(posedge CLK); #1;
        in_valid = 1'b0;
        chk("pre_rst_out_valid", 32'(out_valid), 32'd1);
        chk("pre_rst_stall_cnt", 32'(stall_cnt), 32'd2);
        #2 RST = 1'b1;
        #1;
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_stall_cnt", 32'(stall_cnt), 32'd0);
        chk("mid_rst_rdata1", out_rdata1, 32'd0);
        @(posedge CLK); #1;
        RST = 1'b0; out_ready = 1'b1;
        issue(32'h00A01820, mk(32'h0, 32'h0, 32'h00001820, 6'h00, 5'd3, 1'b1));

        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            n++;
            @(negedge CLK);
        end
        chk("final_drain", 32'(exp_q.size()), 32'd0);
        repeat (2) @(negedge CLK);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_id.md
PIPE_ID -- requirements
Module: pipe_id

Interface
REQ-001 Parameter DATA_W, 32, register and immediate-extension data width (>=16).
REQ-002 Parameter NREGS, 32, register count (power of two, 2..32); ADDR_W = clog2(NREGS).
REQ-003 Port CLK  in  1  sole clock, rising edge.
REQ-004 Port RST  in  1  reset; asynchronous, active-high.
REQ-005 Port in_valid  in  1  Ins holds an instruction; in_ready  out  1  ID accepts it this cycle.
REQ-006 Port Ins  in  32  MIPS instruction (op[31:26], rs[25:21], rt[20:16], rd[15:11], imm[15:0]).
REQ-007 Port wb_en  in  1, wb_adr  in  ADDR_W, wb_data  in  DATA_W  write-back port.
REQ-008 Port out_valid  out  1  ID/EX register holds an instruction; out_ready  in  1  EX consumes it.
REQ-009 Port out_rdata1, out_rdata2, out_ed  out  DATA_W  rs value, rt value, extended immediate.
REQ-010 Port out_op  out  6, out_wadr  out  ADDR_W, out_we  out  1  opcode, destination, write enable.
REQ-011 Port stall_cnt  out  16  saturating count of load-use bubbles inserted.

Function
REQ-012 in_ready SHALL equal (!out_valid || out_ready) && !hazard.
REQ-013 On in_valid && in_ready, the ID/EX register SHALL load decoded fields at the next edge; latency one cycle.
REQ-014 On out_ready && out_valid with no accept, out_valid SHALL fall to 0 (bubble); with out_ready=0, outputs SHALL hold.
REQ-015 Register addresses SHALL use the low ADDR_W bits of rs/rt/rd; register 0 SHALL read 0 and never be written.
REQ-016 Immediate SHALL zero-extend for ops 0x0C/0x0D/0x0E, sign-extend otherwise, to DATA_W.
REQ-017 Destination SHALL be 31 (masked to ADDR_W) for op 0x03, rd for op 0x00, rt otherwise.
REQ-018 out_we SHALL be 0 for ops 0x04, 0x05, 0x02, 0x2B, and 1 otherwise.
REQ-019 Register write SHALL occur at the edge where wb_en=1 and wb_adr!=0, regardless of handshake state.
REQ-020 hazard SHALL be 1 when in_valid && out_valid && out_op==0x23 && out_wadr!=0 && (out_wadr==rs || (out_wadr==rt && Ins reads rt: ops 0x00,0x04,0x05,0x2B)).
REQ-021 On hazard with out_ready=1, exactly one bubble SHALL be inserted and stall_cnt SHALL increment, saturating at 0xFFFF.
REQ-022 On hazard with out_ready=0, no bubble SHALL be counted; ID/EX holds.
REQ-023 Simultaneous wb_en write and read of the same nonzero address: see REQ-028.

Reset
REQ-024 RST=1 SHALL asynchronously clear all registers, out_valid, all out_* data fields and stall_cnt to 0.
REQ-025 in_ready SHALL be 0 while RST=1; an instruction presented during reset SHALL be dropped.
REQ-026 After RST deassertion the first accepted instruction SHALL read all registers as 0.

Configuration
REQ-027 Macro PIPE_ID_WB_BYPASS_EN SHALL select write-back bypass.
REQ-028 With it defined, a read of an address written in the same cycle SHALL return wb_data; without it, the pre-write value.

Structure
REQ-029 Opcode constants (OP_RTYPE, OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_LW, OP_SW, OP_ANDI, OP_ORI, OP_XORI) SHALL reside in shared package mips_pkg.
REQ-030 Register storage SHALL be sub-module regfile_2r1w (parameters DATA_W, NREGS; two async reads, one sync write, async clear).
REQ-031 Decode, hazard, ID/EX register and counter SHALL reside in pipe_id.

Verification
REQ-032 Write 0x12345678 to r5, then issue add r3,r5,r0 -> out_rdata1=0x12345678, out_wadr=3, out_we=1.
REQ-033 Issue ori r2,r0,0x8000 and addi r2,r0,0x8000 -> out_ed=0x00008000 then 0xFFFF8000.
REQ-034 lw r4 followed by add r6,r4,r1 with out_ready=1 -> one bubble, stall_cnt=1; lw r4 then sw r4 base r0 -> bubble; lw r0 then add using r0 -> no bubble.
REQ-035 Hold out_ready=0 for 3 cycles with in_valid=1 -> outputs stable, in_ready=0, nothing lost.
REQ-036 wb_en to r7 with 0xA5A5A5A5 while decoding a read of r7 -> 0xA5A5A5A5 with macro, old value without.
REQ-037 Assert RST mid-stream with out_valid=1 -> out_valid=0, stall_cnt=0, r5 reads 0 afterwards.
